// File: rtl/ram_1p_scrubber.sv
// ============================================================================
// Module   : ram_1p_scrubber
// Brief    : Zero-initialises a single-port RAM on request and periodically
//            scrubs it in the background, counting ECC errors reported on
//            reads. Define RAM_SCRUB_WRITEBACK_EN to write corrected data back.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_1p_scrubber #(
  parameter int Depth    = 512,
  parameter int Width    = 32,
  parameter int Interval = 1024,
  localparam int Aw      = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             init_req_i,
  input  logic             scrub_en_i,
  output logic             req_o,
  output logic             write_o,
  output logic [Aw-1:0]    addr_o,
  output logic [Width-1:0] wdata_o,
  output logic [Width-1:0] wmask_o,
  input  logic             gnt_i,
  input  logic             rvalid_i,
  input  logic [Width-1:0] rdata_i,
  input  logic [1:0]       rerror_i,
  output logic             init_done_o,
  output logic             busy_o,
  output logic [7:0]       corr_cnt_o,
  output logic [7:0]       uncorr_cnt_o,
  output logic             err_valid_o,
  output logic [Aw-1:0]    err_addr_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_RD    = 3'd2;
  localparam logic [2:0] S_RWAIT = 3'd3;
`ifdef RAM_SCRUB_WRITEBACK_EN
  localparam logic [2:0] S_WB    = 3'd4;
`endif
  localparam logic [2:0] S_WAIT  = 3'd5;

  localparam logic [Aw-1:0] AddrLast = Aw'(Depth - 1);
  localparam logic [15:0]   WaitLoad = 16'(Interval - 1);

  logic [2:0]       state_q, state_d;
  logic [Aw-1:0]    init_addr_q, init_addr_d;
  logic [Aw-1:0]    scrub_addr_q, scrub_addr_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic             init_pend_q, init_pend_d;
  logic             init_done_q, init_done_d;
  logic [7:0]       corr_cnt_q, corr_cnt_d;
  logic [7:0]       uncorr_cnt_q, uncorr_cnt_d;
  logic             err_valid_q, err_valid_d;
  logic [Aw-1:0]    err_addr_q, err_addr_d;
`ifdef RAM_SCRUB_WRITEBACK_EN
  logic [Width-1:0] wb_data_q, wb_data_d;
`else
  logic             unused_rdata;
  assign unused_rdata = ^rdata_i;
`endif

  logic acc;
  logic go_init;
  logic leave_access;

  assign acc = req_o & gnt_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      init_addr_q  <= '0;
      scrub_addr_q <= '0;
      wait_cnt_q   <= '0;
      init_pend_q  <= 1'b0;
      init_done_q  <= 1'b0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
      err_valid_q  <= 1'b0;
      err_addr_q   <= '0;
`ifdef RAM_SCRUB_WRITEBACK_EN
      wb_data_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      init_addr_q  <= init_addr_d;
      scrub_addr_q <= scrub_addr_d;
      wait_cnt_q   <= wait_cnt_d;
      init_pend_q  <= init_pend_d;
      init_done_q  <= init_done_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
      err_valid_q  <= err_valid_d;
      err_addr_q   <= err_addr_d;
`ifdef RAM_SCRUB_WRITEBACK_EN
      wb_data_q    <= wb_data_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    init_addr_d  = init_addr_q;
    scrub_addr_d = scrub_addr_q;
    wait_cnt_d   = wait_cnt_q;
    init_pend_d  = init_pend_q;
    init_done_d  = init_done_q;
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    err_valid_d  = 1'b0;
    err_addr_d   = err_addr_q;
`ifdef RAM_SCRUB_WRITEBACK_EN
    wb_data_d    = wb_data_q;
`endif
    go_init      = 1'b0;
    leave_access = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (init_req_i)      go_init = 1'b1;
        else if (scrub_en_i) state_d = S_RD;
      end
      S_INIT: begin
        if (acc) begin
          if (init_addr_q == AddrLast) begin
            init_addr_d = '0;
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            init_addr_d = init_addr_q + Aw'(1);
          end
        end
      end
      S_RD: begin
        // Once accepted the read must complete; an init request is deferred.
        if (acc) begin
          state_d     = S_RWAIT;
          init_pend_d = init_req_i;
        end else if (init_req_i) begin
          go_init = 1'b1;
        end
      end
      S_RWAIT: begin
        if (init_req_i) init_pend_d = 1'b1;
        if (rvalid_i) begin
          if (rerror_i[1]) begin
            err_valid_d = 1'b1;
            err_addr_d  = scrub_addr_q;
            if (uncorr_cnt_q != 8'hFF) uncorr_cnt_d = uncorr_cnt_q + 8'd1;
          end
          if (rerror_i == 2'b01 && corr_cnt_q != 8'hFF) corr_cnt_d = corr_cnt_q + 8'd1;
`ifdef RAM_SCRUB_WRITEBACK_EN
          if (rerror_i == 2'b01) begin
            wb_data_d = rdata_i;
            state_d   = S_WB;
          end else begin
            leave_access = 1'b1;
          end
`else
          leave_access = 1'b1;
`endif
        end
      end
`ifdef RAM_SCRUB_WRITEBACK_EN
      S_WB: begin
        if (init_req_i) init_pend_d = 1'b1;
        if (acc) leave_access = 1'b1;
      end
`endif
      S_WAIT: begin
        if (init_req_i) begin
          go_init = 1'b1;
        end else if (wait_cnt_q == 16'd0) begin
          state_d = scrub_en_i ? S_RD : S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (leave_access) begin
      scrub_addr_d = (scrub_addr_q == AddrLast) ? '0 : scrub_addr_q + Aw'(1);
      if (init_pend_q || init_req_i) begin
        go_init = 1'b1;
      end else begin
        state_d    = S_WAIT;
        wait_cnt_d = WaitLoad;
      end
    end

    if (go_init) begin
      state_d      = S_INIT;
      init_addr_d  = '0;
      init_pend_d  = 1'b0;
      init_done_d  = 1'b0;
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end
  end

  // Outputs: request fields depend only on registered state, so they hold until accepted.
  always_comb begin
    req_o   = 1'b0;
    write_o = 1'b0;
    addr_o  = '0;
    wdata_o = '0;
    busy_o  = (state_q != S_IDLE) && (state_q != S_WAIT);
    case (state_q)
      S_INIT: begin
        req_o   = 1'b1;
        write_o = 1'b1;
        addr_o  = init_addr_q;
      end
      S_RD: begin
        req_o  = 1'b1;
        addr_o = scrub_addr_q;
      end
`ifdef RAM_SCRUB_WRITEBACK_EN
      S_WB: begin
        req_o   = 1'b1;
        write_o = 1'b1;
        addr_o  = scrub_addr_q;
        wdata_o = wb_data_q;
      end
`endif
      default: ;
    endcase
  end

  assign wmask_o      = '1;
  assign init_done_o  = init_done_q;
  assign corr_cnt_o   = corr_cnt_q;
  assign uncorr_cnt_o = uncorr_cnt_q;
  assign err_valid_o  = err_valid_q;
  assign err_addr_o   = err_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_1p_scrubber.sv
// Scoreboard bench for ram_1p_scrubber (Depth=8, Interval=4) with a RAM
// responder model of programmable read latency and per-address error table.
`default_nettype none

module tb_ram_1p_scrubber;
  localparam int Depth    = 8;
  localparam int Width    = 32;
  localparam int Interval = 4;
  localparam int Aw       = 3;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             init_req_i = 1'b0;
  logic             scrub_en_i = 1'b0;
  logic             gnt_i = 1'b0;
  logic             rvalid_i = 1'b0;
  logic [Width-1:0] rdata_i = '0;
  logic [1:0]       rerror_i = 2'b00;
  logic             req_o, write_o, init_done_o, busy_o, err_valid_o;
  logic [Aw-1:0]    addr_o, err_addr_o;
  logic [Width-1:0] wdata_o, wmask_o;
  logic [7:0]       corr_cnt_o, uncorr_cnt_o;

  ram_1p_scrubber #(.Depth(Depth), .Width(Width), .Interval(Interval)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .init_req_i(init_req_i), .scrub_en_i(scrub_en_i),
    .req_o(req_o), .write_o(write_o), .addr_o(addr_o), .wdata_o(wdata_o), .wmask_o(wmask_o),
    .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .rerror_i(rerror_i),
    .init_done_o(init_done_o), .busy_o(busy_o), .corr_cnt_o(corr_cnt_o),
    .uncorr_cnt_o(uncorr_cnt_o), .err_valid_o(err_valid_o), .err_addr_o(err_addr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic             wr;
    logic [Aw-1:0]    addr;
    logic [Width-1:0] data;
  } txn_t;

  txn_t          exp_q[$];
  logic [Aw-1:0] err_q[$];
  int            acc_log[$];
  int            rd_cyc_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  int            cyc = 0;
  int            last_rv_cyc = -1;
  int            rd_lat = 1;
  int            lat_cnt = 0;
  int            base;
  logic [Aw-1:0] pend_addr;
  logic [1:0]       tbl_err [Depth];
  logic [Width-1:0] tbl_data[Depth];
  txn_t          e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_empty(input string name, input int maxc);
    int k = 0;
    while (exp_q.size() != 0 && k < maxc) begin
      @(posedge clk_i);
      k++;
    end
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL %s timeout: %0d transactions left, expected 0", name, exp_q.size());
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  function automatic txn_t mk(input logic wr, input int a, input logic [Width-1:0] d);
    mk.wr   = wr;
    mk.addr = Aw'(a);
    mk.data = d;
  endfunction

  always @(posedge clk_i) cyc = cyc + 1;

  // RAM model: answers each accepted read after rd_lat cycles, independent of DUT reset.
  always @(negedge clk_i) begin
    rvalid_i = 1'b0;
    if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        rvalid_i    = 1'b1;
        rdata_i     = tbl_data[pend_addr];
        rerror_i    = tbl_err[pend_addr];
        last_rv_cyc = cyc;
      end
    end
    if (rst_ni && req_o && gnt_i && !write_o) begin
      lat_cnt   = rd_lat;
      pend_addr = addr_o;
    end
  end

  // Monitor: every accepted request and every error pulse pops the scoreboard.
  always @(negedge clk_i) begin
    if (rst_ni && req_o && gnt_i) begin
      acc_log.push_back(cyc);
      if (!write_o) rd_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_req: got wr=%0d addr=%0d data=%0h, expected none",
                 write_o, addr_o, wdata_o);
      end else begin
        e = exp_q.pop_front();
        check("req_txn", {write_o, addr_o, wdata_o}, e);
        check("wmask", wmask_o, {Width{1'b1}});
      end
    end
    if (rst_ni && err_valid_o) begin
      if (err_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_err: got err_addr=%0d, expected no pulse", err_addr_o);
      end else begin
        check("err_addr", err_addr_o, err_q.pop_front());
      end
    end
  end

  initial begin
    for (int a = 0; a < Depth; a++) begin
      tbl_err[a]  = 2'b00;
      tbl_data[a] = '0;
    end

    // Reset values
    repeat (3) @(negedge clk_i);
    check("rst_req", req_o, 0);
    check("rst_write", write_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_init_done", init_done_o, 0);
    check("rst_counts", {corr_cnt_o, uncorr_cnt_o}, 0);
    check("rst_err_valid", err_valid_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Init pass: 8 zero writes
    for (int a = 0; a < Depth; a++) exp_q.push_back(mk(1'b1, a, '0));
    gnt_i      = 1'b1;
    init_req_i = 1'b1;
    step(1);
    init_req_i = 1'b0;
    wait_empty("init", 40);
    @(negedge clk_i);
    check("init_done", init_done_o, 1);
    check("init_busy", busy_o, 0);

    // Scrub walk 0..7 and wrap to 0; correctable at 3, uncorrectable at 5
    tbl_err[3]  = 2'b01;
    tbl_data[3] = 32'hA5A5A5A5;
    tbl_err[5]  = 2'b10;
    for (int a = 0; a <= Depth; a++) begin
      exp_q.push_back(mk(1'b0, a % Depth, '0));
`ifdef RAM_SCRUB_WRITEBACK_EN
      if (a == 3) exp_q.push_back(mk(1'b1, 3, 32'hA5A5A5A5));
`endif
    end
    err_q.push_back(Aw'(5));
    @(posedge clk_i); #1;
    scrub_en_i = 1'b1;
    wait_empty("scrub", 300);
    #1;
    scrub_en_i = 1'b0;
    step(10);
    @(negedge clk_i);
    check("scrub_corr", corr_cnt_o, 1);
    check("scrub_uncorr", uncorr_cnt_o, 1);
    check("scrub_busy", busy_o, 0);
    // Read, one response cycle, then Interval idle cycles before the next read
    check("gap_0_1", rd_cyc_q[1] - rd_cyc_q[0], Interval + 2);
    check("gap_1_2", rd_cyc_q[2] - rd_cyc_q[1], Interval + 2);
    tbl_err[3] = 2'b00;
    tbl_err[5] = 2'b00;

    // Grant stall for 10 cycles in RD, then init request during RWAIT
    @(posedge clk_i); #1;
    gnt_i  = 1'b0;
    rd_lat = 3;
    exp_q.push_back(mk(1'b0, 1, '0));
    scrub_en_i = 1'b1;
    @(posedge clk_i);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("stall_hold", {req_o, write_o, addr_o}, {1'b1, 1'b0, 3'd1});
    end
    @(posedge clk_i); #1;
    gnt_i      = 1'b1;
    scrub_en_i = 1'b0;
    wait_empty("stall_rd", 10);
    #1;
    base = acc_log.size();
    for (int a = 0; a < Depth; a++) exp_q.push_back(mk(1'b1, a, '0));
    init_req_i = 1'b1;
    step(1);
    init_req_i = 1'b0;
    wait_empty("init2", 60);
    step(3);
    @(negedge clk_i);
    check("init2_done", init_done_o, 1);
    check("init2_clr_cnt", {corr_cnt_o, uncorr_cnt_o}, 0);
    check("init2_after_rvalid", acc_log[base], last_rv_cyc + 1);

    // Saturation: 300 correctable errors starting at scrub address 2
    for (int a = 0; a < Depth; a++) begin
      tbl_err[a]  = 2'b01;
      tbl_data[a] = 32'hC0DE0000 | a;
    end
    rd_lat = 2;
    for (int k = 0; k < 300; k++) begin
      exp_q.push_back(mk(1'b0, (2 + k) % Depth, '0));
`ifdef RAM_SCRUB_WRITEBACK_EN
      exp_q.push_back(mk(1'b1, (2 + k) % Depth, 32'hC0DE0000 | ((2 + k) % Depth)));
`endif
    end
    @(posedge clk_i); #1;
    scrub_en_i = 1'b1;
    wait_empty("saturate", 4000);
    #1;
    scrub_en_i = 1'b0;
    step(12);
    @(negedge clk_i);
    check("sat_corr", corr_cnt_o, 8'hFF);
    check("sat_uncorr", uncorr_cnt_o, 0);

    // Reset during RWAIT; the late uncorrectable response must be ignored
    for (int a = 0; a < Depth; a++) tbl_err[a] = 2'b00;
    tbl_err[6] = 2'b10;
    rd_lat = 3;
    @(posedge clk_i); #1;
    exp_q.push_back(mk(1'b0, 6, '0));
    scrub_en_i = 1'b1;
    wait_empty("rst_rd", 30);
    #1;
    scrub_en_i = 1'b0;
    rst_ni     = 1'b0;
    @(negedge clk_i);
    check("midrst_req", {req_o, write_o, busy_o, init_done_o, err_valid_o}, 0);
    check("midrst_cnt", {corr_cnt_o, uncorr_cnt_o}, 0);
    check("midrst_addr", {addr_o, wdata_o}, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    step(10);
    @(negedge clk_i);
    check("late_rvalid_uncorr", uncorr_cnt_o, 0);
    check("late_rvalid_busy", {busy_o, req_o}, 0);
    check("exp_q_drained", exp_q.size(), 0);
    check("err_q_drained", err_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_1p_scrubber.md
RAM_1P_SCRUBBER -- requirements
Module: ram_1p_scrubber

Interface
REQ-001 Parameter Depth, default 512: words in the target single-port RAM.
REQ-002 Parameter Width, default 32: data width of the target RAM port.
REQ-003 Parameter Interval, default 1024: idle cycles between scrub reads; legal range 1 to 65535.
REQ-004 Localparam Aw = vbits(Depth): address width.
REQ-005 clk_i  input  1  clock; rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 init_req_i  input  1  pulse: zero-initialise the entire RAM.
REQ-007 scrub_en_i  input  1  level: enable periodic background scrubbing.
REQ-008 req_o  output  1, write_o  output  1, addr_o  output  Aw, wdata_o  output  Width, wmask_o  output  Width: request port towards the RAM.
REQ-009 gnt_i  input  1  grant from the external arbiter; a request is accepted in a cycle with req_o & gnt_i.
REQ-010 rvalid_i  input  1, rdata_i  input  Width, rerror_i  input  2: read response (rerror_i bit1 uncorrectable, bit0 correctable).
REQ-011 init_done_o  output  1  set when an init pass has completed.
REQ-012 busy_o  output  1  high in any state other than IDLE and WAIT.
REQ-013 corr_cnt_o  output  8, uncorr_cnt_o  output  8: saturating error counters.
REQ-014 err_valid_o  output  1, err_addr_o  output  Aw: one-cycle pulse with the address of an uncorrectable error.

Function
REQ-015 FSM states: IDLE, INIT, RD, RWAIT, WB, WAIT.
REQ-016 req_o, write_o, addr_o, wdata_o and wmask_o are held stable from assertion until acceptance; wmask_o is always all-ones.
REQ-017 IDLE: init_req_i goes to INIT with addr 0; otherwise scrub_en_i goes to RD.
REQ-018 INIT: write_o=1, wdata_o=0; on acceptance, addr increments; acceptance at Depth-1 sets init_done_o, clears the address to 0 and goes to IDLE.
REQ-019 RD: write_o=0 at the scrub address; on acceptance go to RWAIT.
REQ-020 At most one read is outstanding at any time; the block waits for rvalid_i with no fixed latency and supports 1-3 cycle RAM pipelines.
REQ-021 RWAIT, on rvalid_i: rerror_i[1] increments uncorr_cnt_o and pulses err_valid_o/err_addr_o in the next cycle.
REQ-022 RWAIT, on rvalid_i: rerror_i==2'b01 increments corr_cnt_o and captures rdata_i, then goes to WB; otherwise the block goes to WAIT.
REQ-023 WB: write_o=1 with the captured corrected data at the same address; on acceptance go to WAIT.
REQ-024 Leaving RWAIT or WB, the scrub address increments and wraps from Depth-1 to 0.
REQ-025 WAIT: a 16-bit counter loads Interval-1 on entry; at 0 the FSM goes to RD if scrub_en_i is high, else to IDLE.
REQ-026 init_req_i in WAIT or IDLE has priority and goes to INIT.
REQ-027 init_req_i in RD (not yet accepted) drops req_o and goes to INIT.
REQ-028 init_req_i in RWAIT or WB is latched and taken after that access completes.
REQ-029 init_req_i during INIT is ignored.
REQ-030 Counters saturate at 255; they are cleared only by reset or by entry to INIT.
REQ-031 rvalid_i outside RWAIT is ignored.
REQ-032 scrub_en_i deassertion takes effect only at an IDLE/WAIT decision point; an in-flight access always completes.

Reset
REQ-033 On rst_ni low, the FSM goes to IDLE, all addresses and counters clear to 0, and req_o, write_o, init_done_o, busy_o and err_valid_o are 0.
REQ-034 Reset mid-access abandons the access; a later rvalid_i for it is discarded by REQ-031.

Configuration
REQ-035 Macro RAM_SCRUB_WRITEBACK_EN defined: REQ-023 write-back is active.
REQ-036 Macro RAM_SCRUB_WRITEBACK_EN undefined: the WB state is not compiled, correctable errors are only counted, and RWAIT goes to WAIT.

Verification
REQ-037 Depth=8, init_req_i pulse with gnt_i=1 -> 8 writes to addresses 0..7 with data 0, then init_done_o=1 and busy_o=0.
REQ-038 scrub_en_i=1, Interval=4, rvalid_i one cycle after acceptance -> reads at addresses 0,1,2 spaced exactly 4 idle cycles apart; address 7 wraps to 0.
REQ-039 Read at address 3 answered with rerror_i=01 and rdata_i=0xA5A5A5A5 -> corr_cnt_o=1 and a write of 0xA5A5A5A5 to address 3 (macro defined); no write occurs when the macro is undefined.
REQ-040 rerror_i=10 at address 5 -> uncorr_cnt_o=1, one-cycle err_valid_o with err_addr_o=5, and no write-back.
REQ-041 gnt_i=0 for 10 cycles during RD -> req_o and addr_o are held stable for all 10 cycles; init_req_i during RWAIT starts INIT right after rvalid_i.
REQ-042 300 correctable errors -> corr_cnt_o holds 255; reset asserted in RWAIT -> all outputs are 0 and a late rvalid_i is ignored.
